// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the instruction cache.
package icache_pkg;

  localparam int unsigned DEF_LINES      = 64;
  localparam int unsigned DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } icache_state_t;

  // Word offset within the line; byte bits [1:0] are dropped.
  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int unsigned off_w);
    return (a >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned off_w,
                                             input int unsigned idx_w);
    return (a >> (off_w + 32'd2)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned off_w,
                                           input int unsigned idx_w);
    return a >> (off_w + idx_w + 32'd2);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-stage to instruction-cache request/response interface.
interface if_icache_inf;
  logic        read_flag;
  logic [31:0] addr;
  logic [31:0] read_data;
  logic        busy;
  logic        done;

  modport icache (input read_flag, addr, output read_data, busy, done);
  modport pif    (output read_flag, addr, input read_data, busy, done);
endinterface

// File: rtl/icache_tag_array.sv
// Per-line valid bits and tags: single write port, synchronous clear-all, combinational read.
module icache_tag_array #(
  parameter int unsigned LINES   = 64,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               we,
  input  logic [INDEX_W-1:0] widx,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [INDEX_W-1:0] ridx,
  output logic               rd_valid_c,
  output logic [TAG_W-1:0]   rd_tag_c
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];

  // Clear wins so a flush can never leave a stale line valid.
  always_comb begin
    valid_d = valid_q;
    if (clear) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[widx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx] <= wtag;
    end
  end

  assign rd_valid_c = valid_q[ridx];
  assign rd_tag_c   = tag_mem[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; refills a whole line word-by-word on a miss.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  if_icache_inf.icache        with_pif,
  input  logic                flush,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack
);

  localparam int unsigned OFFSET_W = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_W  = $clog2(LINES);
  localparam int unsigned TAG_W    = 30 - OFFSET_W - INDEX_W;
  localparam int unsigned DEPTH    = LINES * LINE_WORDS;
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

  icache_state_t       state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         read_data_q, read_data_d;
  logic                flush_pend_q, flush_pend_d;
  logic [31:0]         buf_q [LINE_WORDS];
  logic [31:0]         buf_d [LINE_WORDS];
  logic [31:0]         rd_word_q;
  logic [31:0]         data_mem [DEPTH];

  logic [TAG_W-1:0]    req_tag_c, tv_tag_c;
  logic [INDEX_W-1:0]  req_idx_c;
  logic [OFFSET_W-1:0] req_off_c;
  logic                tv_valid_c, hit_c, miss_c, busy_c, done_c, accept_c;
  logic                ack_c, last_c, flush_clear_c;
  logic [31:0]         word_c;

  assign req_tag_c = TAG_W'(addr_tag(with_pif.addr, OFFSET_W, INDEX_W));
  assign req_idx_c = INDEX_W'(addr_index(with_pif.addr, OFFSET_W, INDEX_W));
  assign req_off_c = OFFSET_W'(addr_offset(with_pif.addr, OFFSET_W));

  icache_tag_array #(
    .LINES  (LINES),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_clear_c),
    .we        (last_c),
    .widx      (idx_q),
    .wtag      (tag_q),
    .ridx      (idx_q),
    .rd_valid_c(tv_valid_c),
    .rd_tag_c  (tv_tag_c)
  );

  assign hit_c    = (state_q == LOOKUP) && tv_valid_c && (tv_tag_c == tag_q);
  assign miss_c   = (state_q == LOOKUP) && !hit_c;
  assign busy_c   = (state_q == REFILL) || miss_c;
  assign done_c   = hit_c || (state_q == RESP);
  assign accept_c = with_pif.read_flag && !busy_c;
  assign word_c   = (state_q == RESP) ? buf_q[off_q] : rd_word_q;
  assign ack_c    = (state_q == REFILL) && mem_req_q && mem_ack;
  assign last_c   = ack_c && (cnt_q == LAST_WORD);

  // A flush seen while a line is being filled is held until that line has been answered.
  assign flush_clear_c = (flush && ((state_q == IDLE) || (state_q == LOOKUP)))
                      || ((state_q == RESP) && (flush_pend_q || flush));

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    flush_pend_d = flush_pend_q;
    buf_d        = buf_q;
    read_data_d  = done_c ? word_c : read_data_q;

    if (accept_c) begin
      tag_d = req_tag_c;
      idx_d = req_idx_c;
      off_d = req_off_c;
    end

    if (state_q == RESP) begin
      flush_pend_d = 1'b0;
    end else if (flush && (state_q == REFILL)) begin
      flush_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE:    if (accept_c) state_d = LOOKUP;
      LOOKUP: begin
        if (hit_c) begin
          state_d = accept_c ? LOOKUP : IDLE;
        end else begin
          state_d    = REFILL;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {tag_q, idx_q, OFFSET_W'(0), 2'b00};
        end
      end
      REFILL: begin
        if (ack_c) begin
          buf_d[cnt_q] = mem_rdata;
          cnt_d        = OFFSET_W'(cnt_q + 1'b1);
          if (last_c) begin
            mem_req_d = 1'b0;
            state_d   = RESP;
          end else begin
            mem_addr_d = {tag_q, idx_q, OFFSET_W'(cnt_q + 1'b1), 2'b00};
          end
        end
      end
      RESP:    state_d = accept_c ? LOOKUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      read_data_q  <= '0;
      flush_pend_q <= 1'b0;
      buf_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      read_data_q  <= read_data_d;
      flush_pend_q <= flush_pend_d;
      buf_q        <= buf_d;
    end
  end

  // Data array: refill write port, synchronous read at request acceptance.
  always_ff @(posedge clk) begin
    if (ack_c) begin
      data_mem[{idx_q, cnt_q}] <= mem_rdata;
    end
    if (accept_c) begin
      rd_word_q <= data_mem[{req_idx_c, req_off_c}];
    end
  end

  assign with_pif.busy      = busy_c;
  assign with_pif.done      = done_c;
  assign with_pif.read_data = done_c ? word_c : read_data_q;
  assign mem_req            = mem_req_q;
  assign mem_addr           = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fills, hits, conflicts, flushes, reset during refill, stray acks.
module tb_icache;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        force_ack = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] ack_log[$];
  int unsigned vecs = 0;
  int unsigned errs = 0;

  if_icache_inf pif_if();

  icache dut (
    .clk      (clk),
    .rst      (rst),
    .with_pif (pif_if),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5AC3_1E00;
  endfunction

  // Memory model: acks each word after MEM_LAT cycles of mem_req; force_ack injects stray acks.
  always @(posedge clk) begin
    #2;
    if (mem_ack) lat_cnt = 0;
    mem_ack = force_ack;
    if (force_ack) mem_rdata = 32'hDEAD_BEEF;
    if (mem_req && !rst) begin
      lat_cnt++;
      if (lat_cnt >= MEM_LAT) begin
        mem_ack   = 1'b1;
        mem_rdata = mw(mem_addr);
        ack_log.push_back(mem_addr);
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // One request from IDLE; reports latency to done, data, mem_req cycles, busy in cycle 1, done after.
  task automatic fetch(input logic [31:0] a, input int flush_at, output int lat,
                       output logic [31:0] data, output int nreq, output logic busy1,
                       output logic done2);
    ack_log.delete();
    pif_if.read_flag = 1'b1;
    pif_if.addr      = a;
    @(posedge clk); #1;
    pif_if.read_flag = 1'b0;
    lat = 0; data = '0; nreq = 0; busy1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = pif_if.busy;
      if (mem_req) nreq++;
      if (flush) flush = 1'b0;
      if (c == flush_at) flush = 1'b1;
      if (pif_if.done) begin
        lat  = c;
        data = pif_if.read_data;
        break;
      end
    end
    @(negedge clk);
    flush = 1'b0;
    done2 = pif_if.done;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vecs++; if (pif_if.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", pif_if.busy); end
    vecs++; if (pif_if.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", pif_if.done); end
    vecs++; if (pif_if.read_data !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h expected 0", pif_if.read_data); end
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    int lat, nreq; logic [31:0] d; logic b1, d2;
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    fetch(32'h4, 0, lat, d, nreq, b1, d2);
    vecs++; if (b1 !== 1'b1) begin errs++; $display("FAIL cold_busy: got %b expected 1", b1); end
    vecs++; if (lat !== 10) begin errs++; $display("FAIL cold_lat: got %0d expected 10", lat); end
    vecs++; if (d !== mw(32'h4)) begin errs++; $display("FAIL cold_data: got %h expected %h", d, mw(32'h4)); end
    vecs++; if (nreq !== 8) begin errs++; $display("FAIL cold_req_cycles: got %0d expected 8", nreq); end
    vecs++; if (d2 !== 1'b0) begin errs++; $display("FAIL cold_done_len: got %b expected 0", d2); end
    vecs++; if (ack_log.size() !== 4) begin errs++; $display("FAIL cold_nacks: got %0d expected 4", ack_log.size()); end
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      vecs++; if (ack_log[i] !== exp_addr[i]) begin errs++; $display("FAIL cold_addr%0d: got %h expected %h", i, ack_log[i], exp_addr[i]); end
    end
  endtask

  task automatic test_hit();
    int lat, nreq; logic [31:0] d; logic b1, d2;
    fetch(32'hC, 0, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 1) begin errs++; $display("FAIL hit_lat: got %0d expected 1", lat); end
    vecs++; if (d !== mw(32'hC)) begin errs++; $display("FAIL hit_data: got %h expected %h", d, mw(32'hC)); end
    vecs++; if (nreq !== 0) begin errs++; $display("FAIL hit_no_req: got %0d expected 0", nreq); end
    vecs++; if (b1 !== 1'b0) begin errs++; $display("FAIL hit_busy: got %b expected 0", b1); end
    vecs++; if (d2 !== 1'b0) begin errs++; $display("FAIL hit_done_len: got %b expected 0", d2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs = '{32'h0, 32'h4, 32'h8};
    pif_if.read_flag = 1'b1;
    pif_if.addr      = addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) pif_if.addr = addrs[i+1];
      else pif_if.read_flag = 1'b0;
      @(negedge clk);
      vecs++; if (pif_if.done !== 1'b1) begin errs++; $display("FAIL b2b_done%0d: got %b expected 1", i, pif_if.done); end
      vecs++; if (pif_if.read_data !== mw(addrs[i])) begin errs++; $display("FAIL b2b_data%0d: got %h expected %h", i, pif_if.read_data, mw(addrs[i])); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    vecs++; if (pif_if.done !== 1'b0) begin errs++; $display("FAIL b2b_idle_done: got %b expected 0", pif_if.done); end
    vecs++; if (pif_if.read_data !== mw(32'h8)) begin errs++; $display("FAIL b2b_hold: got %h expected %h", pif_if.read_data, mw(32'h8)); end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    int lat, nreq; logic [31:0] d; logic b1, d2;
    fetch(32'h400, 0, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL conf_lat: got %0d expected 10", lat); end
    vecs++; if (d !== mw(32'h400)) begin errs++; $display("FAIL conf_data: got %h expected %h", d, mw(32'h400)); end
    vecs++; if (ack_log.size() !== 4 || ack_log[0] !== 32'h400 || ack_log[3] !== 32'h40C) begin
      errs++; $display("FAIL conf_addrs: got %0d acks expected 0x400..0x40C", ack_log.size());
    end
    fetch(32'h0, 0, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL conf_evict_lat: got %0d expected 10", lat); end
    vecs++; if (d !== mw(32'h0)) begin errs++; $display("FAIL conf_evict_data: got %h expected %h", d, mw(32'h0)); end
  endtask

  task automatic test_flush();
    int lat, nreq; logic [31:0] d; logic b1, d2;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch(32'h0, 0, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL flush_idle_lat: got %0d expected 10", lat); end
    fetch(32'h10, 4, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL flush_refill_lat: got %0d expected 10", lat); end
    vecs++; if (d !== mw(32'h10)) begin errs++; $display("FAIL flush_refill_data: got %h expected %h", d, mw(32'h10)); end
    fetch(32'h10, 0, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL flush_after_lat: got %0d expected 10", lat); end
  endtask

  task automatic test_reset_mid_refill();
    int lat, nreq; logic [31:0] d; logic b1, d2;
    bit seen;
    ack_log.delete();
    seen = 1'b0;
    pif_if.read_flag = 1'b1;
    pif_if.addr      = 32'h20;
    @(posedge clk); #1;
    pif_if.read_flag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack_log.size() >= 2) begin seen = 1'b1; break; end
    end
    vecs++; if (!seen) begin errs++; $display("FAIL rmid_wait: got %0d acks expected 2", ack_log.size()); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rmid_mem_req: got %b expected 0", mem_req); end
    vecs++; if (pif_if.busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b expected 0", pif_if.busy); end
    vecs++; if (pif_if.done !== 1'b0) begin errs++; $display("FAIL rmid_done: got %b expected 0", pif_if.done); end
    @(posedge clk); #1;
    fetch(32'h20, 0, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL rmid_refetch_lat: got %0d expected 10", lat); end
    vecs++; if (d !== mw(32'h20)) begin errs++; $display("FAIL rmid_refetch_data: got %h expected %h", d, mw(32'h20)); end
  endtask

  task automatic test_spurious_ack();
    int lat, nreq; logic [31:0] d; logic b1, d2;
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vecs++; if (pif_if.busy !== 1'b0 || pif_if.done !== 1'b0 || mem_req !== 1'b0) begin
        errs++; $display("FAIL spur_state: got busy=%b done=%b req=%b expected 0 0 0", pif_if.busy, pif_if.done, mem_req);
      end
      @(posedge clk); #1;
    end
    force_ack = 1'b0;
    @(posedge clk); #1;
    fetch(32'h20, 0, lat, d, nreq, b1, d2);
    vecs++; if (lat !== 1) begin errs++; $display("FAIL spur_hit_lat: got %0d expected 1", lat); end
    vecs++; if (d !== mw(32'h20)) begin errs++; $display("FAIL spur_hit_data: got %h expected %h", d, mw(32'h20)); end
  endtask

  initial begin
    pif_if.read_flag = 1'b0;
    pif_if.addr      = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_reset_mid_refill();
    test_spurious_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
